// File: rtl/modport_fifo.sv
// Synchronous single-clock FIFO with registered read data and count-decoded flags.
// Storage is not reset; pointers and count are, so stale entries are never readable.
module modport_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] wdata,
  input  logic             i_wreq,
  input  logic             i_rreq,
  output logic [WIDTH-1:0] rdata,
  output logic             fifo_isempty,
  output logic             fifo_isfull,
  output logic             o_rready,
  output logic             o_wready
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             wr_en, rd_en;

  // Flags depend only on the registered count, never on the requests.
  assign fifo_isempty = (cnt_q == '0);
  assign fifo_isfull  = (cnt_q == FULL_CNT);
  assign o_rready     = ~fifo_isempty;
  assign o_wready     = ~fifo_isfull;
  assign rdata        = rdata_q;

  assign wr_en = i_wreq & o_wready;
  assign rd_en = i_rreq & o_rready;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    if (wr_en) wptr_d = wptr_q + 1'b1;
    if (rd_en) begin
      rptr_d  = rptr_q + 1'b1;
      rdata_d = mem_q[rptr_q];
    end
    case ({wr_en, rd_en})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: tb/tb_modport_fifo.sv
// Randomized bench for modport_fifo against a queue-based reference model.
module tb_modport_fifo;
  localparam int W = 8;
  localparam int D = 16;

  logic         clk = 1'b0;
  logic         resetn;
  logic [W-1:0] wdata;
  logic         i_wreq, i_rreq;
  logic [W-1:0] rdata;
  logic         fifo_isempty, fifo_isfull, o_rready, o_wready;

  modport_fifo #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .resetn(resetn), .wdata(wdata), .i_wreq(i_wreq), .i_rreq(i_rreq),
    .rdata(rdata), .fifo_isempty(fifo_isempty), .fifo_isfull(fifo_isfull),
    .o_rready(o_rready), .o_wready(o_wready)
  );

  always #5 clk = ~clk;

  int           n_cmp = 0;
  int           n_err = 0;
  logic [W-1:0] mq[$];
  logic [W-1:0] exp_rd = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag);
    int n;
    n = mq.size();
    chk({tag, ".rdata"}, 32'(rdata), 32'(exp_rd));
    chk({tag, ".empty"}, 32'(fifo_isempty), 32'(n == 0));
    chk({tag, ".full"},  32'(fifo_isfull),  32'(n == D));
    chk({tag, ".rrdy"},  32'(o_rready),     32'(n != 0));
    chk({tag, ".wrdy"},  32'(o_wready),     32'(n != D));
  endtask

  // Called 1ns after a rising edge; drives one cycle of requests and checks the result.
  task automatic cyc(input string tag, input logic w, input logic r, input logic [W-1:0] d);
    bit acc_w, acc_r;
    i_wreq = w; i_rreq = r; wdata = d;
    acc_w = w && (mq.size() < D);
    acc_r = r && (mq.size() > 0);
    @(posedge clk); #1;
    if (acc_r) exp_rd = mq.pop_front();
    if (acc_w) mq.push_back(d);
    i_wreq = 1'b0; i_rreq = 1'b0;
    check_outs(tag);
  endtask

  task automatic reset_pulse(input string tag);
    resetn = 1'b0;
    #1;
    mq.delete();
    exp_rd = '0;
    check_outs(tag);
    #1 resetn = 1'b1;
  endtask

  initial begin
    int bias_w, bias_r;
    resetn = 1'b0; i_wreq = 1'b0; i_rreq = 1'b0; wdata = '0;
    #2;
    check_outs("reset");
    // Requests during reset must be ignored.
    i_wreq = 1'b1; i_rreq = 1'b1; wdata = 8'h77;
    @(posedge clk); #1;
    check_outs("reset_req");
    i_wreq = 1'b0; i_rreq = 1'b0;
    resetn = 1'b1;
    @(posedge clk); #1;

    // Fill / drain
    for (int i = 1; i <= D; i++) cyc("fill", 1'b1, 1'b0, W'(i));
    chk("fill.full_after16", 32'(fifo_isfull), 32'd1);
    // Overflow: write while full is dropped
    cyc("ovf", 1'b1, 1'b0, 8'hAA);
    for (int i = 1; i <= D; i++) begin
      cyc("drain", 1'b0, 1'b1, 8'h00);
      chk("drain.order", 32'(rdata), 32'(i));
    end
    chk("drain.empty", 32'(fifo_isempty), 32'd1);
    // Underflow: rdata holds last value
    cyc("udf", 1'b0, 1'b1, 8'h00);
    chk("udf.hold", 32'(rdata), 32'h10);

    // Shift pointers so the simultaneous run wraps
    for (int i = 0; i < 12; i++) cyc("shift_w", 1'b1, 1'b0, 8'($urandom));
    for (int i = 0; i < 12; i++) cyc("shift_r", 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 5; i++) cyc("pre5", 1'b1, 1'b0, 8'h30 + 8'(i));
    for (int i = 0; i < 10; i++) cyc("simul", 1'b1, 1'b1, 8'h40 + 8'(i));
    chk("simul.count5", 32'(mq.size()), 32'd5);
    for (int i = 0; i < 5; i++) cyc("simul_drain", 1'b0, 1'b1, 8'h00);

    // Boundary simultaneous requests
    cyc("both_empty", 1'b1, 1'b1, 8'h66);
    chk("both_empty.notempty", 32'(fifo_isempty), 32'd0);
    for (int i = 0; i < D - 1; i++) cyc("to_full", 1'b1, 1'b0, 8'($urandom));
    cyc("both_full", 1'b1, 1'b1, 8'h99);
    chk("both_full.notfull", 32'(fifo_isfull), 32'd0);

    // Mid-operation reset
    reset_pulse("rst_full");
    for (int i = 0; i < 3; i++) cyc("prerst", 1'b1, 1'b0, 8'h11 * 8'(i + 1));
    reset_pulse("rst_mid");
    cyc("post_w", 1'b1, 1'b0, 8'h5C);
    cyc("post_r", 1'b0, 1'b1, 8'h00);
    chk("post_r.5c", 32'(rdata), 32'h5C);

    // Random traffic with drifting bias so both full and empty get exercised
    bias_w = 50; bias_r = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 100 == 0) begin
        bias_w = $urandom_range(10, 90);
        bias_r = $urandom_range(10, 90);
      end
      if (c % 700 == 699) reset_pulse("rnd_rst");
      else cyc("rnd", ($urandom_range(0, 99) < bias_w), ($urandom_range(0, 99) < bias_r),
               8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
